// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_main_control
//  Brief    : Main control FSM for the multi-cycle MIPS core. It sequences the
//             shared ALU, memory port, IR, PC and register file, waits on the
//             memory ready handshake with a timeout, and counts retired
//             instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  // The wait counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int                WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_r;
  state_t             state_nx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               bus_error_r;
  logic [CNT_W-1:0]   retired_r;
  logic               waiting;
  logic               timeout_hit;

  // Memory stall detection and timeout decision for the current cycle.
  always_comb begin
    waiting     = 1'b0;
    timeout_hit = 1'b0;
    if ((state_r == S_FETCH) || (state_r == S_MEM_READ) || (state_r == S_MEM_WRITE)) begin
      waiting = !mem_ready;
    end
    if ((TIMEOUT_CYCLES != 0) && waiting && (wait_cnt == WAIT_LAST)) begin
      timeout_hit = 1'b1;
    end
  end

  // Next-state and Moore output decode; reset forces every output low.
  always_comb begin
    state_nx    = state_r;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b000000:            state_nx = S_EXEC;
          6'b100011, 6'b101011: state_nx = S_MEM_ADDR;
          6'b000100:            state_nx = S_BRANCH;
          6'b000010:            state_nx = S_JUMP;
          6'b001000:            state_nx = S_ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_nx   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = (opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_nx = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        state_nx = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_nx    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
    // A stalled memory state that has hit its limit halts instead.
    if (timeout_hit) state_nx = S_HALT;
    if (rst) begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  // State register, wait counter, sticky bus error and retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FETCH;
      wait_cnt    <= '0;
      bus_error_r <= 1'b0;
      retired_r   <= '0;
    end else begin
      state_r <= state_nx;
      if (state_nx != state_r) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_hit) bus_error_r <= 1'b1;
      if (instr_done)  retired_r   <= retired_r + CNT_W'(1);
    end
  end

  assign state     = rst ? 4'd0 : state_r;
  assign bus_error = rst ? 1'b0 : bus_error_r;
  assign retired   = rst ? '0   : retired_r;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_main_control
//  Brief    : Self-checking bench for multicycle_main_control. An instruction-
//             level model (per-class step lists) predicts every output each
//             cycle; directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ready = 1'b0;
  logic          IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
  logic          ALUSrcA, PCWrite, PCWriteCond, instr_done, illegal_op, bus_error;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  multicycle_main_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .instr_done(instr_done), .illegal_op(illegal_op),
    .bus_error(bus_error), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: instruction class (0 R,1 lw,2 sw,3 beq,4 j,5 addi,6 illegal) and
  // step index (0 fetch, 1 decode, 2.. class-specific steps).
  int seq_len [7]    = '{2, 3, 2, 1, 1, 2, 0};
  int seq_tab [7][3] = '{'{6, 7, 0}, '{2, 3, 4}, '{2, 5, 0}, '{8, 0, 0},
                         '{9, 0, 0}, '{10, 11, 0}, '{0, 0, 0}};
  int m_step = 0, m_cls = 0, m_wait = 0, m_retired = 0;
  bit m_halt = 0, m_bus = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      OP_R:    return 0;
      OP_LW:   return 1;
      OP_SW:   return 2;
      OP_BEQ:  return 3;
      OP_J:    return 4;
      OP_ADDI: return 5;
      default: return 6;
    endcase
  endfunction

  // Per-state control word: {IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,
  // ALUSrcA,ALUSrcB,ALUOp,PCSource,PCWriteCond}, straight from the state table.
  function automatic logic [13:0] ctl_of(input int code);
    logic iord, mr, mw, m2r, rd, rw, sa, pwc;
    logic [1:0] sb, op, ps;
    {iord, mr, mw, m2r, rd, rw, sa, pwc} = 8'd0;
    sb = 2'd0; op = 2'd0; ps = 2'd0;
    case (code)
      0:  begin mr = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9:  ps = 2'b10;
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {iord, mr, mw, m2r, rd, rw, sa, sb, op, ps, pwc};
  endfunction

  // One clock: drive inputs after the falling edge, compare every output
  // against the model, then advance the model for the coming rising edge.
  task automatic cycle(input bit r, input bit rdy, input logic [5:0] op);
    int code, cls_now;
    bit is_mem, completes, tmo, last, done, ill, irw, pcw;
    logic [17:0] exp_v, act_v;
    int exp_state, exp_ret;
    bit exp_bus;
    @(negedge clk);
    rst = r; mem_ready = rdy; opcode = op;
    #1;
    code = 0; cls_now = m_cls; completes = 0; tmo = 0; last = 0; done = 0;
    if (r) begin
      exp_v = '0; exp_state = 0; exp_ret = 0; exp_bus = 0;
    end else if (m_halt) begin
      exp_v = '0; exp_state = 12; exp_ret = m_retired; exp_bus = m_bus;
    end else begin
      if (m_step == 1) cls_now = classify(op);
      code      = (m_step == 0) ? 0 : (m_step == 1) ? 1 : seq_tab[m_cls][m_step-2];
      is_mem    = (code == 0) || (code == 3) || (code == 5);
      completes = !is_mem || rdy;
      tmo       = is_mem && !rdy && (TMO != 0) && (m_wait + 1 == TMO);
      last      = (m_step >= 1) && (m_step - 1 == seq_len[cls_now]);
      done      = completes && last && (cls_now != 6);
      ill       = (m_step == 1) && (cls_now == 6);
      irw       = (code == 0) && rdy;
      pcw       = ((code == 0) && rdy) || (code == 9);
      exp_v     = {ctl_of(code), irw, pcw, done, ill};
      exp_state = code; exp_ret = m_retired; exp_bus = m_bus;
    end
    act_v = {IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
             ALUOp, PCSource, PCWriteCond, IRWrite, PCWrite, instr_done, illegal_op};
    chk("controls", 32'(act_v), 32'(exp_v));
    chk("state", 32'(state), 32'(exp_state));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("bus_error", 32'(bus_error), 32'(exp_bus));
    if (r) begin
      m_step = 0; m_cls = 0; m_wait = 0; m_retired = 0; m_halt = 0; m_bus = 0;
    end else if (!m_halt) begin
      if (tmo) begin
        m_halt = 1; m_bus = 1; m_wait = 0;
      end else if (completes) begin
        m_wait = 0;
        if (m_step == 1) m_cls = cls_now;
        if (done) m_retired = (m_retired + 1) % (1 << CW);
        if (last) m_step = 0;
        else      m_step++;
      end else begin
        m_wait++;
      end
    end
  endtask

  initial begin
    int burst;
    logic [5:0] rop;
    // R-type after a 2-cycle reset.
    cycle(1, 1, OP_R); cycle(1, 1, OP_R);
    cycle(0, 1, OP_R); chk("r_fetch", 32'(state), 0); chk("r_irwrite", 32'(IRWrite), 1);
    cycle(0, 1, OP_R); chk("r_decode", 32'(state), 1);
    cycle(0, 1, OP_R); chk("r_exec", 32'(state), 6); chk("r_aluop", 32'(ALUOp), 2);
    cycle(0, 1, OP_R); chk("r_wb", 32'(state), 7);
    chk("r_wb_ctl", 32'({RegWrite, RegDst, instr_done}), 32'b111);
    // lw with three stalled MEM_READ cycles: 8 cycles total.
    cycle(0, 1, OP_LW); chk("lw_fetch", 32'(state), 0); chk("r_retired", 32'(retired), 1);
    cycle(0, 1, OP_LW); cycle(0, 1, OP_LW); chk("lw_addr", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      cycle(0, (i == 3), OP_LW);
      chk("lw_read", 32'({state, MemRead, IorD}), 32'({4'd3, 2'b11}));
    end
    cycle(0, 1, OP_LW); chk("lw_wb", 32'({state, RegWrite, MemtoReg}), 32'({4'd4, 2'b11}));
    // beq then j.
    cycle(0, 1, OP_BEQ); chk("lw_retired", 32'(retired), 2);
    cycle(0, 1, OP_BEQ); cycle(0, 1, OP_BEQ);
    chk("beq_ctl", 32'({state, ALUOp, PCWriteCond, PCSource}), 32'({4'd8, 2'b01, 1'b1, 2'b01}));
    cycle(0, 1, OP_J); cycle(0, 1, OP_J); cycle(0, 1, OP_J);
    chk("j_ctl", 32'({state, PCWrite, PCSource}), 32'({4'd9, 1'b1, 2'b10}));
    // Illegal opcode then addi.
    cycle(0, 1, OP_BAD); chk("bj_retired", 32'(retired), 4);
    cycle(0, 1, OP_BAD); chk("ill_pulse", 32'({state, illegal_op}), 32'({4'd1, 1'b1}));
    cycle(0, 1, OP_ADDI); chk("ill_back", 32'({state, retired}), 32'({4'd0, 4'd4}));
    cycle(0, 1, OP_ADDI);
    cycle(0, 1, OP_ADDI); chk("addi_exec", 32'({state, ALUSrcB}), 32'({4'd10, 2'b10}));
    cycle(0, 1, OP_ADDI);
    chk("addi_wb", 32'({state, RegDst, RegWrite, instr_done}), 32'({4'd11, 3'b011}));
    // Timeout in FETCH after 4 stalled cycles.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, OP_J); chk("tmo_wait", 32'(state), 0);
    end
    cycle(0, 1, OP_J);
    chk("tmo_halt", 32'({state, bus_error, MemRead}), 32'({4'd12, 1'b1, 1'b0}));
    cycle(0, 1, OP_J); chk("halt_stay", 32'(state), 12);
    cycle(1, 1, OP_J); chk("rst_bus", 32'(bus_error), 0);
    // 16 jumps wrap the 4-bit retired count.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, OP_J); chk("wrap_cnt", 32'(retired), 32'(i));
      cycle(0, 1, OP_J); cycle(0, 1, OP_J);
    end
    cycle(0, 1, OP_LW); chk("wrap_zero", 32'(retired), 0);
    cycle(0, 1, OP_LW); cycle(0, 1, OP_LW);
    cycle(0, 0, OP_LW); chk("rst_mid_rd", 32'(state), 3);
    cycle(1, 0, OP_LW); chk("rst_mid_done", 32'({instr_done, MemRead}), 0);
    cycle(0, 1, OP_LW);
    chk("rst_mid_fetch", 32'({state, MemRead, IorD, retired}), 32'({4'd0, 2'b10, 4'd0}));
    // Randomized traffic.
    burst = 0;
    rop = OP_LW;
    for (int n = 0; n < 3000; n++) begin
      bit r, rdy;
      if (m_step == 0) begin
        case ($urandom_range(0, 6))
          0: rop = OP_R;   1: rop = OP_LW;  2: rop = OP_SW;  3: rop = OP_BEQ;
          4: rop = OP_J;   5: rop = OP_ADDI;
          default: rop = 6'($urandom);
        endcase
      end
      r = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      if (burst > 0) begin
        rdy = 0; burst--;
      end else begin
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(3, 6);
        rdy = ($urandom_range(0, 99) < 75);
      end
      cycle(r, rdy, rop);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS variant of the core.
- Sequences one shared ALU, memory port, IR, PC and register file over several cycles per instruction.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00=add, 01=sub, 10=use funct.
- Handles a ready handshake on the shared instruction/data memory, a memory-wait timeout, and retired-instruction counting.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive mem_ready=0 cycles in any memory state before halting; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes current read/write this cycle
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR
MemtoReg  output  1  1=MDR to register write data
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=rs
ALUSrcB  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU zero (beq)
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode
bus_error  output  1  sticky, memory timeout occurred
retired  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
state  output  4  current state, for debug

Behaviour:
- Outputs are decoded from state (Moore), except IRWrite/PCWrite in FETCH and instr_done in MEM_WRITE, which are gated by mem_ready. Any signal not listed for a state is 0.
- While rst=1: all outputs 0; at the clock edge state<=FETCH, retired<=0, bus_error<=0, wait counter<=0. The first cycle after deassertion is FETCH. Reset mid-instruction abandons it without retiring it.
- States/encodings:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; ->DECODE on mem_ready, else stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Next state by opcode:
    - 000000 -> EXEC
    - 100011/101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - other -> illegal_op=1, ->FETCH, not retired
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEM_READ, sw->MEM_WRITE (opcode held stable by IR).
  - MEM_READ(3): MemRead=1, IorD=1; ->MEM_WB on mem_ready.
  - MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; ->FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1; on mem_ready: instr_done=1, ->FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->R_WB.
  - R_WB(7): RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1; ->FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; ->FETCH.
  - JUMP(9): PCWrite=1, PCSource=10, instr_done=1; ->FETCH.
  - ADDI_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDI_WB.
  - ADDI_WB(11): RegDst=0, RegWrite=1, MemtoReg=0, instr_done=1; ->FETCH.
  - HALT(12): all outputs 0 except bus_error/retired/state; stays until rst.
  - Encodings 13-15: ->FETCH next cycle, outputs 0.
- Cycle counts at zero wait: R/addi=4, lw=5, sw=4, beq=3, j=3. Each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 while mem_ready=0: bus_error<=1, ->HALT; no IRWrite/PCWrite that cycle.
  - mem_ready=1 on the same cycle the limit is reached takes priority: normal completion.
- retired increments by 1 on every cycle instr_done=1; wraps all-ones->0.

Test Plan:
- rst=1 for 2 cycles then 0, mem_ready=1, opcode=000000 -> state 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=RegDst=1 in R_WB; instr_done once; retired=1.
- lw (100011), mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with MemRead=IorD=1; MEM_WB asserts RegWrite=MemtoReg=1; total 8 cycles.
- beq (000100) then j (000010) -> BRANCH: ALUOp=01, PCWriteCond=1, PCSource=01; JUMP: PCWrite=1, PCSource=10; retired=2 after 6 cycles.
- opcode=111111 -> illegal_op pulse in DECODE, back to FETCH, retired unchanged; then addi (001000) completes in 4 cycles with ALUSrcB=10, RegDst=0.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> after 4 wait cycles state=12, bus_error=1, MemRead=0; stays until rst, which clears bus_error.
- CNT_W=4, 16 jumps -> retired wraps 15->0; rst asserted in MEM_READ -> next cycle FETCH, MemRead from PC, no instr_done.
